// File: rtl/branch_update_unit.sv
// Branch update unit: tracks in-flight predictions in FIFO order and emits table write-backs
// on resolution. Optional counters enabled by defining BRANCH_UPDATE_STATS_EN.
module branch_update_unit #(
    parameter int unsigned PC_WIDTH   = 10,
    parameter int unsigned HIST_WIDTH = 3,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pred_valid,
    input  logic [PC_WIDTH-1:0]   pred_pc,
    input  logic                  pred_taken,
    output logic                  pred_ready,
    output logic [HIST_WIDTH-1:0] lookup_history,
    input  logic                  resolve_valid,
    input  logic                  resolve_taken,
    output logic                  upd_we,
    output logic [PC_WIDTH-1:0]   upd_pc,
    output logic [HIST_WIDTH-1:0] upd_history,
    output logic                  upd_taken,
    output logic                  mispredict,
    output logic [HIST_WIDTH-1:0] commit_history
`ifdef BRANCH_UPDATE_STATS_EN
    ,
    output logic [15:0]           stat_resolved,
    output logic [15:0]           stat_mispredicts
`endif
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [PC_WIDTH-1:0]   ent_pc_q   [DEPTH];
    logic [HIST_WIDTH-1:0] ent_hist_q [DEPTH];
    logic                  ent_pred_q [DEPTH];

    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       count_q, count_d;
    logic [HIST_WIDTH-1:0] spec_hist_q, spec_hist_d;
    logic [HIST_WIDTH-1:0] commit_hist_q, commit_hist_d;
    logic                  upd_we_q, upd_we_d;
    logic [PC_WIDTH-1:0]   upd_pc_q, upd_pc_d;
    logic [HIST_WIDTH-1:0] upd_history_q, upd_history_d;
    logic                  upd_taken_q, upd_taken_d;
    logic                  mispredict_q, mispredict_d;

    logic not_full;
    logic resolve_fire;
    logic resolve_mis;
    logic resolve_ok;
    logic push_do;

    always_comb begin
        not_full     = (count_q < CntW'(DEPTH));
        resolve_fire = resolve_valid && (count_q != '0);
        resolve_mis  = resolve_fire && (resolve_taken != ent_pred_q[rd_ptr_q]);
        resolve_ok   = resolve_fire && !resolve_mis;
        // A correct resolve frees a slot this cycle, so a push is taken even when full;
        // a mispredict means the pushed branch is on the wrong path.
        push_do      = pred_valid && (not_full || resolve_ok) && !resolve_mis;
    end

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        spec_hist_d   = spec_hist_q;
        commit_hist_d = commit_hist_q;
        upd_we_d      = resolve_fire;
        upd_pc_d      = upd_pc_q;
        upd_history_d = upd_history_q;
        upd_taken_d   = upd_taken_q;
        mispredict_d  = resolve_mis;

        if (resolve_fire) begin
            upd_pc_d      = ent_pc_q[rd_ptr_q];
            upd_history_d = ent_hist_q[rd_ptr_q];
            upd_taken_d   = resolve_taken;
            commit_hist_d = {commit_hist_q[HIST_WIDTH-2:0], resolve_taken};
        end

        if (resolve_mis) begin
            count_d     = '0;
            rd_ptr_d    = wr_ptr_q;
            spec_hist_d = {commit_hist_q[HIST_WIDTH-2:0], resolve_taken};
        end else begin
            if (push_do) begin
                wr_ptr_d    = wr_ptr_q + PtrW'(1);
                spec_hist_d = {spec_hist_q[HIST_WIDTH-2:0], pred_taken};
            end
            if (resolve_ok) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            if (push_do && !resolve_ok) begin
                count_d = count_q + CntW'(1);
            end else if (!push_do && resolve_ok) begin
                count_d = count_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            spec_hist_q   <= '0;
            commit_hist_q <= '0;
            upd_we_q      <= 1'b0;
            upd_pc_q      <= '0;
            upd_history_q <= '0;
            upd_taken_q   <= 1'b0;
            mispredict_q  <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            spec_hist_q   <= spec_hist_d;
            commit_hist_q <= commit_hist_d;
            upd_we_q      <= upd_we_d;
            upd_pc_q      <= upd_pc_d;
            upd_history_q <= upd_history_d;
            upd_taken_q   <= upd_taken_d;
            mispredict_q  <= mispredict_d;
        end
    end

    // Entry storage needs no reset: slots are only read when count marks them valid.
    always_ff @(posedge clk) begin
        if (push_do) begin
            ent_pc_q[wr_ptr_q]   <= pred_pc;
            ent_hist_q[wr_ptr_q] <= spec_hist_q;
            ent_pred_q[wr_ptr_q] <= pred_taken;
        end
    end

    assign pred_ready     = not_full;
    assign lookup_history = spec_hist_q;
    assign upd_we         = upd_we_q;
    assign upd_pc         = upd_pc_q;
    assign upd_history    = upd_history_q;
    assign upd_taken      = upd_taken_q;
    assign mispredict     = mispredict_q;
    assign commit_history = commit_hist_q;

`ifdef BRANCH_UPDATE_STATS_EN
    logic [15:0] stat_res_q, stat_res_d;
    logic [15:0] stat_mis_q, stat_mis_d;

    always_comb begin
        stat_res_d = stat_res_q;
        stat_mis_d = stat_mis_q;
        if (resolve_fire && (stat_res_q != 16'hFFFF)) begin
            stat_res_d = stat_res_q + 16'd1;
        end
        if (resolve_mis && (stat_mis_q != 16'hFFFF)) begin
            stat_mis_d = stat_mis_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_res_q <= '0;
            stat_mis_q <= '0;
        end else begin
            stat_res_q <= stat_res_d;
            stat_mis_q <= stat_mis_d;
        end
    end

    assign stat_resolved    = stat_res_q;
    assign stat_mispredicts = stat_mis_q;
`endif

endmodule

// File: tb/tb_branch_update_unit.sv
// Directed self-checking bench for branch_update_unit (DEPTH=4, HIST_WIDTH=3, PC_WIDTH=10).
// Stats checks are compiled in when BRANCH_UPDATE_STATS_EN is defined.
module tb_branch_update_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pred_valid = 1'b0;
    logic [9:0] pred_pc = '0;
    logic       pred_taken = 1'b0;
    logic       pred_ready;
    logic [2:0] lookup_history;
    logic       resolve_valid = 1'b0;
    logic       resolve_taken = 1'b0;
    logic       upd_we;
    logic [9:0] upd_pc;
    logic [2:0] upd_history;
    logic       upd_taken;
    logic       mispredict;
    logic [2:0] commit_history;
`ifdef BRANCH_UPDATE_STATS_EN
    logic [15:0] stat_resolved;
    logic [15:0] stat_mispredicts;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    branch_update_unit #(
        .PC_WIDTH  (10),
        .HIST_WIDTH(3),
        .DEPTH     (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pred_valid    (pred_valid),
        .pred_pc       (pred_pc),
        .pred_taken    (pred_taken),
        .pred_ready    (pred_ready),
        .lookup_history(lookup_history),
        .resolve_valid (resolve_valid),
        .resolve_taken (resolve_taken),
        .upd_we        (upd_we),
        .upd_pc        (upd_pc),
        .upd_history   (upd_history),
        .upd_taken     (upd_taken),
        .mispredict    (mispredict),
        .commit_history(commit_history)
`ifdef BRANCH_UPDATE_STATS_EN
        ,
        .stat_resolved   (stat_resolved),
        .stat_mispredicts(stat_mispredicts)
`endif
    );

    // One clock with the given inputs; returns 1 ns after the edge with valids dropped.
    task automatic cyc(input logic pv, input logic [9:0] pc, input logic pt,
                       input logic rv, input logic rt);
        pred_valid    = pv;
        pred_pc       = pc;
        pred_taken    = pt;
        resolve_valid = rv;
        resolve_taken = rt;
        @(posedge clk);
        #1;
        pred_valid    = 1'b0;
        resolve_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #7;
        total++; if (upd_we !== 1'b0) begin bad++; $display("FAIL rst_upd_we got=%b exp=0", upd_we); end
        total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL rst_mispredict got=%b exp=0", mispredict); end
        total++; if (pred_ready !== 1'b1) begin bad++; $display("FAIL rst_pred_ready got=%b exp=1", pred_ready); end
        total++; if (lookup_history !== 3'b000) begin bad++; $display("FAIL rst_lookup got=%b exp=000", lookup_history); end
        total++; if (commit_history !== 3'b000) begin bad++; $display("FAIL rst_commit got=%b exp=000", commit_history); end
        total++; if (upd_pc !== 10'h000) begin bad++; $display("FAIL rst_upd_pc got=%h exp=000", upd_pc); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_push_resolve();
        do_reset();
        cyc(1'b1, 10'h005, 1'b1, 1'b0, 1'b0);
        total++; if (lookup_history !== 3'b001) begin bad++; $display("FAIL push1_lookup got=%b exp=001", lookup_history); end
        cyc(1'b1, 10'h006, 1'b0, 1'b0, 1'b0);
        total++; if (lookup_history !== 3'b010) begin bad++; $display("FAIL push2_lookup got=%b exp=010", lookup_history); end
        total++; if (pred_ready !== 1'b1) begin bad++; $display("FAIL push2_ready got=%b exp=1", pred_ready); end
        cyc(1'b0, 10'h000, 1'b0, 1'b1, 1'b1);
        total++; if (upd_we !== 1'b1) begin bad++; $display("FAIL res1_we got=%b exp=1", upd_we); end
        total++; if (upd_pc !== 10'h005) begin bad++; $display("FAIL res1_pc got=%h exp=005", upd_pc); end
        total++; if (upd_history !== 3'b000) begin bad++; $display("FAIL res1_hist got=%b exp=000", upd_history); end
        total++; if (upd_taken !== 1'b1) begin bad++; $display("FAIL res1_taken got=%b exp=1", upd_taken); end
        total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL res1_mis got=%b exp=0", mispredict); end
        total++; if (commit_history !== 3'b001) begin bad++; $display("FAIL res1_commit got=%b exp=001", commit_history); end
        cyc(1'b0, 10'h000, 1'b0, 1'b1, 1'b0);
        total++; if (upd_pc !== 10'h006) begin bad++; $display("FAIL res2_pc got=%h exp=006", upd_pc); end
        total++; if (upd_history !== 3'b001) begin bad++; $display("FAIL res2_hist got=%b exp=001", upd_history); end
        total++; if (commit_history !== 3'b010) begin bad++; $display("FAIL res2_commit got=%b exp=010", commit_history); end
        cyc(1'b0, 10'h000, 1'b0, 1'b0, 1'b0);
        total++; if (upd_we !== 1'b0) begin bad++; $display("FAIL idle_we got=%b exp=0", upd_we); end
    endtask

    task automatic test_full();
        logic [9:0] exp_pc [5];
        logic [2:0] exp_h  [5];
        exp_pc = '{10'h002, 10'h003, 10'h004, 10'h00A, 10'h000};
        exp_h  = '{3'b001, 3'b011, 3'b111, 3'b111, 3'b000};
        do_reset();
        for (int i = 1; i <= 4; i++) cyc(1'b1, 10'(i), 1'b1, 1'b0, 1'b0);
        total++; if (pred_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", pred_ready); end
        total++; if (lookup_history !== 3'b111) begin bad++; $display("FAIL full_lookup got=%b exp=111", lookup_history); end
        cyc(1'b1, 10'h009, 1'b0, 1'b0, 1'b0);
        total++; if (lookup_history !== 3'b111) begin bad++; $display("FAIL ign_lookup got=%b exp=111", lookup_history); end
        cyc(1'b1, 10'h00A, 1'b1, 1'b1, 1'b1);
        total++; if (upd_pc !== 10'h001) begin bad++; $display("FAIL fullres_pc got=%h exp=001", upd_pc); end
        total++; if (pred_ready !== 1'b0) begin bad++; $display("FAIL fullres_ready got=%b exp=0", pred_ready); end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 10'h000, 1'b0, 1'b1, 1'b1);
            total++; if (upd_pc !== exp_pc[i] || upd_we !== 1'b1) begin
                bad++; $display("FAIL drain%0d got pc=%h we=%b exp pc=%h we=1", i, upd_pc, upd_we, exp_pc[i]);
            end
            total++; if (upd_history !== exp_h[i]) begin
                bad++; $display("FAIL drain%0d_hist got=%b exp=%b", i, upd_history, exp_h[i]);
            end
        end
        total++; if (pred_ready !== 1'b1) begin bad++; $display("FAIL drained_ready got=%b exp=1", pred_ready); end
        cyc(1'b0, 10'h000, 1'b0, 1'b1, 1'b1);
        total++; if (upd_we !== 1'b0) begin bad++; $display("FAIL empty_we got=%b exp=0", upd_we); end
    endtask

    task automatic test_mispredict();
        do_reset();
        cyc(1'b1, 10'h010, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 10'h020, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 10'h030, 1'b1, 1'b0, 1'b0);
        total++; if (lookup_history !== 3'b101) begin bad++; $display("FAIL abc_lookup got=%b exp=101", lookup_history); end
        cyc(1'b0, 10'h000, 1'b0, 1'b1, 1'b0);
        total++; if (mispredict !== 1'b1 || upd_we !== 1'b1) begin
            bad++; $display("FAIL mis_pulse got mis=%b we=%b exp 1 1", mispredict, upd_we);
        end
        total++; if (upd_pc !== 10'h010) begin bad++; $display("FAIL mis_pc got=%h exp=010", upd_pc); end
        total++; if (lookup_history !== 3'b000) begin bad++; $display("FAIL mis_lookup got=%b exp=000", lookup_history); end
        total++; if (commit_history !== 3'b000) begin bad++; $display("FAIL mis_commit got=%b exp=000", commit_history); end
        cyc(1'b0, 10'h000, 1'b0, 1'b1, 1'b1);
        total++; if (upd_we !== 1'b0 || mispredict !== 1'b0) begin
            bad++; $display("FAIL flushed_res got we=%b mis=%b exp 0 0", upd_we, mispredict);
        end
        total++; if (commit_history !== 3'b000) begin bad++; $display("FAIL flushed_commit got=%b exp=000", commit_history); end
    endtask

    task automatic test_mispredict_push();
        do_reset();
        cyc(1'b1, 10'h100, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 10'h3FF, 1'b1, 1'b1, 1'b1);
        total++; if (mispredict !== 1'b1) begin bad++; $display("FAIL mp_mis got=%b exp=1", mispredict); end
        total++; if (upd_pc !== 10'h100) begin bad++; $display("FAIL mp_pc got=%h exp=100", upd_pc); end
        total++; if (lookup_history !== 3'b001) begin bad++; $display("FAIL mp_lookup got=%b exp=001", lookup_history); end
        total++; if (commit_history !== 3'b001) begin bad++; $display("FAIL mp_commit got=%b exp=001", commit_history); end
        cyc(1'b0, 10'h000, 1'b0, 1'b1, 1'b1);
        total++; if (upd_we !== 1'b0) begin bad++; $display("FAIL mp_dropped_we got=%b exp=0", upd_we); end
        cyc(1'b1, 10'h050, 1'b1, 1'b0, 1'b0);
        total++; if (lookup_history !== 3'b011) begin bad++; $display("FAIL mp_push_lookup got=%b exp=011", lookup_history); end
        cyc(1'b0, 10'h000, 1'b0, 1'b1, 1'b1);
        total++; if (upd_pc !== 10'h050 || upd_history !== 3'b001) begin
            bad++; $display("FAIL mp_after got pc=%h hist=%b exp 050 001", upd_pc, upd_history);
        end
        total++; if (commit_history !== 3'b011) begin bad++; $display("FAIL mp_after_commit got=%b exp=011", commit_history); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        cyc(1'b1, 10'h011, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 10'h022, 1'b1, 1'b1, 1'b1);
        total++; if (upd_pc !== 10'h011 || upd_history !== 3'b000) begin
            bad++; $display("FAIL b2b0 got pc=%h hist=%b exp 011 000", upd_pc, upd_history);
        end
        cyc(1'b1, 10'h033, 1'b0, 1'b1, 1'b1);
        total++; if (upd_pc !== 10'h022 || upd_history !== 3'b001 || upd_we !== 1'b1) begin
            bad++; $display("FAIL b2b1 got pc=%h hist=%b we=%b exp 022 001 1", upd_pc, upd_history, upd_we);
        end
        cyc(1'b0, 10'h000, 1'b0, 1'b1, 1'b0);
        total++; if (upd_pc !== 10'h033 || upd_history !== 3'b011 || mispredict !== 1'b0) begin
            bad++; $display("FAIL b2b2 got pc=%h hist=%b mis=%b exp 033 011 0", upd_pc, upd_history, mispredict);
        end
        total++; if (commit_history !== 3'b110) begin bad++; $display("FAIL b2b_commit got=%b exp=110", commit_history); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cyc(1'b1, 10'h077, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 10'h078, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 10'h000, 1'b0, 1'b1, 1'b1);
        rst_n = 1'b0;
        #1;
        total++; if (upd_we !== 1'b0) begin bad++; $display("FAIL mid_we got=%b exp=0", upd_we); end
        total++; if (lookup_history !== 3'b000 || commit_history !== 3'b000) begin
            bad++; $display("FAIL mid_hist got look=%b commit=%b exp 000 000", lookup_history, commit_history);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc(1'b0, 10'h000, 1'b0, 1'b1, 1'b1);
        total++; if (upd_we !== 1'b0) begin bad++; $display("FAIL mid_empty_we got=%b exp=0", upd_we); end
    endtask

`ifdef BRANCH_UPDATE_STATS_EN
    task automatic test_stats();
        do_reset();
        cyc(1'b1, 10'h001, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 10'h000, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 10'h002, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 10'h000, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 10'h003, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 10'h000, 1'b0, 1'b1, 1'b0);
        total++; if (stat_resolved !== 16'd3) begin bad++; $display("FAIL stat_res got=%0d exp=3", stat_resolved); end
        total++; if (stat_mispredicts !== 16'd1) begin bad++; $display("FAIL stat_mis got=%0d exp=1", stat_mispredicts); end
        cyc(1'b1, 10'h004, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 65535; i++) cyc(1'b1, 10'h004, 1'b1, 1'b1, 1'b1);
        total++; if (stat_resolved !== 16'hFFFF) begin bad++; $display("FAIL stat_sat got=%h exp=ffff", stat_resolved); end
        cyc(1'b0, 10'h000, 1'b0, 1'b1, 1'b1);
        total++; if (stat_resolved !== 16'hFFFF) begin bad++; $display("FAIL stat_hold got=%h exp=ffff", stat_resolved); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (stat_resolved !== 16'd0 || stat_mispredicts !== 16'd0) begin
            bad++; $display("FAIL stat_rst got res=%0d mis=%0d exp 0 0", stat_resolved, stat_mispredicts);
        end
        rst_n = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_push_resolve();
        test_full();
        test_mispredict();
        test_mispredict_push();
        test_back_to_back();
        test_reset_mid();
`ifdef BRANCH_UPDATE_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
